// File: rtl/vdc_raster_timing_gen.sv
// vdc_raster_timing_gen
// Register-programmable H/V raster timing for the HuC6270 VDC. CPU-written
// timing registers are shadowed at safe raster boundaries. The block drives
// sync, display and BG-fetch windows, the char-cycle phase and per-line scroll
// latches. It also raises sticky raster-compare (RCR) and vertical-blank (VBL)
// interrupts.
module vdc_raster_timing_gen #(
  parameter int CHAR_CYCLES = 8,
  parameter int CC_W        = $clog2(CHAR_CYCLES),
  parameter int RASTER_BASE = 64,
  parameter int CNT_W       = 10
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             reg_we,
  input  logic [4:0]       reg_addr,
  input  logic [15:0]      reg_wdata,
  input  logic [1:0]       irq_ack,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             h_disp,
  output logic             v_disp,
  output logic             bg_fetch,
  output logic [CC_W-1:0]  char_cycle,
  output logic             eol,
  output logic [CNT_W-1:0] raster_line,
  output logic [CNT_W-1:0] x_start,
  output logic [CNT_W-1:0] y_start,
  output logic [1:0]       irq_flags,
  output logic             irq_n
);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_WAIT = 2'd1,
    PH_DISP = 2'd2,
    PH_END  = 2'd3
  } phase_e;

  localparam logic [15:0] HSR_RST = 16'h0202;
  localparam logic [15:0] HDR_RST = 16'h031F;
  localparam logic [15:0] VSR_RST = 16'h0F02;
  localparam logic [15:0] VDR_RST = 16'h00EF;
  localparam logic [15:0] VCR_RST = 16'h0003;

  localparam logic [CC_W-1:0] CC_LAST  = CC_W'(CHAR_CYCLES - 1);
  localparam logic [CC_W-1:0] CC_LATCH = CC_W'(CHAR_CYCLES - 2);

  // Live CPU-visible register fields
  logic             r_rcr_en;
  logic             r_vbl_en;
  logic [CNT_W-1:0] r_rcr;
  logic [CNT_W-1:0] r_bxr;
  logic [CNT_W-1:0] r_byr;
  logic [4:0]       r_hsw;
  logic [6:0]       r_hds;
  logic [6:0]       r_hdw;
  logic [6:0]       r_hde;
  logic [4:0]       r_vsw;
  logic [7:0]       r_vds;
  logic [8:0]       r_vdw;
  logic [7:0]       r_vde;

  // Shadow copies used by the counters
  logic [6:0]       r_sh_hds;
  logic [6:0]       r_sh_hdw;
  logic [6:0]       r_sh_hde;
  logic [7:0]       r_sh_vds;
  logic [8:0]       r_sh_vdw;
  logic [7:0]       r_sh_vde;

  // Timing state
  logic [CC_W-1:0]  r_cc;
  phase_e           r_h_state;
  logic [CNT_W-1:0] r_h_cnt;
  phase_e           r_v_state;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] r_raster;
  logic [CNT_W-1:0] r_x_start;
  logic [CNT_W-1:0] r_y_start;
  logic             r_eol_d;
  logic [1:0]       r_irq_flags;
  logic             r_irq_n;

  // Decoded timing events
  logic             w_cc_last;
  logic             w_eol;
  logic             w_v_last;
  logic             w_enter_vdisp;
  logic             w_enter_vend;
  logic             w_enter_vsync;
  logic [7:0]       w_vde_eff;
  logic [1:0]       w_irq_set;

  assign w_cc_last     = (r_cc == CC_LAST);
  assign w_eol         = (r_h_state == PH_END) && (r_h_cnt == '0) && w_cc_last;
  assign w_v_last      = (r_v_cnt == '0);
  assign w_enter_vdisp = w_eol && (r_v_state == PH_WAIT) && w_v_last;
  assign w_enter_vend  = w_eol && (r_v_state == PH_DISP) && w_v_last;
  assign w_enter_vsync = w_eol && (r_v_state == PH_END)  && w_v_last;
  assign w_vde_eff     = (r_sh_vde == '0) ? 8'd1 : r_sh_vde;
  assign w_irq_set     = {w_enter_vend && r_vbl_en,
                          r_eol_d && r_rcr_en && (r_raster == r_rcr)};

  // Register file: a write strobe updates the live field on the next clock
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_rcr_en <= 1'b0;
      r_vbl_en <= 1'b0;
      r_rcr    <= '0;
      r_bxr    <= '0;
      r_byr    <= '0;
      r_hsw    <= HSR_RST[4:0];
      r_hds    <= HSR_RST[14:8];
      r_hdw    <= HDR_RST[6:0];
      r_hde    <= HDR_RST[14:8];
      r_vsw    <= VSR_RST[4:0];
      r_vds    <= VSR_RST[15:8];
      r_vdw    <= VDR_RST[8:0];
      r_vde    <= VCR_RST[7:0];
    end else if (reg_we) begin
      case (reg_addr)
        5'h05: begin
          r_rcr_en <= reg_wdata[2];
          r_vbl_en <= reg_wdata[3];
        end
        5'h06: r_rcr <= reg_wdata[CNT_W-1:0];
        5'h07: r_bxr <= reg_wdata[CNT_W-1:0];
        5'h08: r_byr <= reg_wdata[CNT_W-1:0];
        5'h0A: begin
          r_hsw <= reg_wdata[4:0];
          r_hds <= reg_wdata[14:8];
        end
        5'h0B: begin
          r_hdw <= reg_wdata[6:0];
          r_hde <= reg_wdata[14:8];
        end
        5'h0C: begin
          r_vsw <= reg_wdata[4:0];
          r_vds <= reg_wdata[15:8];
        end
        5'h0D: r_vdw <= reg_wdata[8:0];
        5'h0E: r_vde <= reg_wdata[7:0];
        default: ;
      endcase
    end
  end

  // H shadow: captured at end of line, i.e. on entry to H_SYNC
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_sh_hds <= HSR_RST[14:8];
      r_sh_hdw <= HDR_RST[6:0];
      r_sh_hde <= HDR_RST[14:8];
    end else if (w_eol) begin
      r_sh_hds <= r_hds;
      r_sh_hdw <= r_hdw;
      r_sh_hde <= r_hde;
    end
  end

  // V shadow: captured on entry to V_SYNC
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_sh_vds <= VSR_RST[15:8];
      r_sh_vdw <= VDR_RST[8:0];
      r_sh_vde <= VCR_RST[7:0];
    end else if (w_enter_vsync) begin
      r_sh_vds <= r_vds;
      r_sh_vdw <= r_vdw;
      r_sh_vde <= r_vde;
    end
  end

  // Character-cell phase, free running
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) r_cc <= '0;
    else          r_cc <= r_cc + CC_W'(1);
  end

  // H phase FSM: each phase lasts field+1 cells, advancing on the last clock of a cell.
  // Sync width is only consumed on the edge that also snapshots it, so the SYNC
  // count takes the value being shadowed on that same edge rather than a stored copy.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_h_state <= PH_SYNC;
      r_h_cnt   <= CNT_W'(HSR_RST[4:0]);
    end else if (w_cc_last) begin
      if (r_h_cnt == '0) begin
        case (r_h_state)
          PH_SYNC: begin
            r_h_state <= PH_WAIT;
            r_h_cnt   <= CNT_W'(r_sh_hds);
          end
          PH_WAIT: begin
            r_h_state <= PH_DISP;
            r_h_cnt   <= CNT_W'(r_sh_hdw);
          end
          PH_DISP: begin
            r_h_state <= PH_END;
            r_h_cnt   <= CNT_W'(r_sh_hde);
          end
          PH_END: begin
            r_h_state <= PH_SYNC;
            r_h_cnt   <= CNT_W'(r_hsw);
          end
        endcase
      end else begin
        r_h_cnt <= r_h_cnt - CNT_W'(1);
      end
    end
  end

  // V phase FSM: line-granular, stepped by eol; VSW is taken the same way as HSW
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_v_state <= PH_WAIT;
      r_v_cnt   <= CNT_W'(VSR_RST[15:8]) + CNT_W'(1);
    end else if (w_eol) begin
      if (w_v_last) begin
        case (r_v_state)
          PH_SYNC: begin
            r_v_state <= PH_WAIT;
            r_v_cnt   <= CNT_W'(r_sh_vds) + CNT_W'(1);
          end
          PH_WAIT: begin
            r_v_state <= PH_DISP;
            r_v_cnt   <= CNT_W'(r_sh_vdw);
          end
          PH_DISP: begin
            r_v_state <= PH_END;
            r_v_cnt   <= CNT_W'(w_vde_eff - 8'd1);
          end
          PH_END: begin
            r_v_state <= PH_SYNC;
            r_v_cnt   <= CNT_W'(r_vsw);
          end
        endcase
      end else begin
        r_v_cnt <= r_v_cnt - CNT_W'(1);
      end
    end
  end

  // Raster counter: restarts at RASTER_BASE on the first displayed line
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)           r_raster <= '0;
    else if (w_enter_vdisp) r_raster <= CNT_W'(RASTER_BASE);
    else if (w_eol)         r_raster <= r_raster + CNT_W'(1);
  end

  // Per-line scroll latches, sampled during H_SYNC one clock before a cell ends
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_x_start <= '0;
      r_y_start <= '0;
    end else if ((r_h_state == PH_SYNC) && (r_cc == CC_LATCH)) begin
      r_x_start <= r_bxr;
      r_y_start <= r_byr;
    end
  end

  // Interrupts: sticky flags, set wins over a same-cycle ack; irq_n lags one clock
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_eol_d     <= 1'b0;
      r_irq_flags <= '0;
      r_irq_n     <= 1'b1;
    end else begin
      r_eol_d     <= w_eol;
      r_irq_flags <= (r_irq_flags & ~irq_ack) | w_irq_set;
      r_irq_n     <= ~|r_irq_flags;
    end
  end

  assign hsync_n     = (r_h_state != PH_SYNC);
  assign vsync_n     = (r_v_state != PH_SYNC);
  assign h_disp      = (r_h_state == PH_DISP);
  assign v_disp      = (r_v_state == PH_DISP);
  assign bg_fetch    = v_disp && (h_disp || ((r_h_state == PH_WAIT) && (r_h_cnt < CNT_W'(2))));
  assign char_cycle  = r_cc;
  assign eol         = w_eol;
  assign raster_line = r_raster;
  assign x_start     = r_x_start;
  assign y_start     = r_y_start;
  assign irq_flags   = r_irq_flags;
  assign irq_n       = r_irq_n;

endmodule

// File: tb/tb_vdc_raster_timing_gen.sv
// tb_vdc_raster_timing_gen
// Directed bench for the raster timing generator. The default timing is 336
// clocks per line and 263 lines per frame. Line L after reset release spans
// clocks 336*L .. 336*L+335.
module tb_vdc_raster_timing_gen;

  logic        clock     = 1'b0;
  logic        reset_N   = 1'b0;
  logic        reg_we    = 1'b0;
  logic [4:0]  reg_addr  = '0;
  logic [15:0] reg_wdata = '0;
  logic [1:0]  irq_ack   = '0;
  logic        hsync_n, vsync_n, h_disp, v_disp, bg_fetch, eol, irq_n;
  logic [2:0]  char_cycle;
  logic [9:0]  raster_line, x_start, y_start;
  logic [1:0]  irq_flags;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  vdc_raster_timing_gen #(
    .CHAR_CYCLES(8),
    .CC_W(3),
    .RASTER_BASE(64),
    .CNT_W(10)
  ) dut (
    .clock(clock), .reset_N(reset_N), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .irq_ack(irq_ack), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .h_disp(h_disp), .v_disp(v_disp), .bg_fetch(bg_fetch), .char_cycle(char_cycle),
    .eol(eol), .raster_line(raster_line), .x_start(x_start), .y_start(y_start),
    .irq_flags(irq_flags), .irq_n(irq_n)
  );

  always #5 clock = ~clock;

  // Clocks elapsed since reset release; sampled on negedges
  always @(posedge clock or negedge reset_N) begin
    if (!reset_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic goto(input int unsigned target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [15:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clock);
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic wait_eol(input int unsigned budget, output int unsigned at);
    at = 0;
    for (int i = 0; i < int'(budget); i++) begin
      @(negedge clock);
      if (eol === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset(input bit mid_frame);
    if (mid_frame) begin
      goto(89200);
      n_checks++; if (h_disp !== 1'b1) begin n_fail++; $display("FAIL pre_reset_h_disp: got %b want 1", h_disp); end
      #2 reset_N = 1'b0;
      #1;
    end else begin
      reset_N = 1'b0;
      repeat (3) @(negedge clock);
    end
    n_checks++; if (hsync_n !== 1'b0) begin n_fail++; $display("FAIL rst_hsync_n: got %b want 0", hsync_n); end
    n_checks++; if (vsync_n !== 1'b1) begin n_fail++; $display("FAIL rst_vsync_n: got %b want 1", vsync_n); end
    n_checks++; if (h_disp !== 1'b0) begin n_fail++; $display("FAIL rst_h_disp: got %b want 0", h_disp); end
    n_checks++; if (v_disp !== 1'b0) begin n_fail++; $display("FAIL rst_v_disp: got %b want 0", v_disp); end
    n_checks++; if (bg_fetch !== 1'b0) begin n_fail++; $display("FAIL rst_bg_fetch: got %b want 0", bg_fetch); end
    n_checks++; if (eol !== 1'b0) begin n_fail++; $display("FAIL rst_eol: got %b want 0", eol); end
    n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq_n: got %b want 1", irq_n); end
    n_checks++; if (char_cycle !== 3'd0) begin n_fail++; $display("FAIL rst_char_cycle: got %0d want 0", char_cycle); end
    n_checks++; if (raster_line !== 10'd0) begin n_fail++; $display("FAIL rst_raster_line: got %0d want 0", raster_line); end
    n_checks++; if (x_start !== 10'd0) begin n_fail++; $display("FAIL rst_x_start: got %0d want 0", x_start); end
    n_checks++; if (y_start !== 10'd0) begin n_fail++; $display("FAIL rst_y_start: got %0d want 0", y_start); end
    n_checks++; if (irq_flags !== 2'b00) begin n_fail++; $display("FAIL rst_irq_flags: got %b want 00", irq_flags); end
    @(negedge clock);
    reset_N = 1'b1;
  endtask

  task automatic test_free_run;
    int unsigned t, hs, hd, ne;
    wait_eol(500, t);
    n_checks++; if (t != 335) begin n_fail++; $display("FAIL first_eol_clock: got %0d want 335", t); end
    hs = 0; hd = 0; ne = 0;
    for (int i = 0; i < 336; i++) begin
      @(negedge clock);
      if (hsync_n === 1'b0) hs++;
      if (h_disp === 1'b1) hd++;
      if (eol === 1'b1) ne++;
    end
    n_checks++; if (eol !== 1'b1) begin n_fail++; $display("FAIL eol_period_336: got eol=%b want 1", eol); end
    n_checks++; if (ne != 1) begin n_fail++; $display("FAIL eol_count_line: got %0d want 1", ne); end
    n_checks++; if (hs != 24) begin n_fail++; $display("FAIL hsync_low_clocks: got %0d want 24", hs); end
    n_checks++; if (hd != 256) begin n_fail++; $display("FAIL h_disp_clocks: got %0d want 256", hd); end
    n_checks++; if (char_cycle !== 3'd7) begin n_fail++; $display("FAIL eol_char_cycle: got %0d want 7", char_cycle); end
  endtask

  task automatic test_x_start;
    int unsigned bad;
    goto(695);
    n_checks++; if (char_cycle !== 3'd7 || hsync_n !== 1'b0) begin n_fail++; $display("FAIL bxr_write_slot: got cc=%0d hs=%b want cc=7 hs=0", char_cycle, hsync_n); end
    reg_write(5'h07, 16'h0013);
    bad = 0;
    while (cyc <= 1014) begin
      if (x_start !== 10'd0) bad++;
      @(negedge clock);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL x_start_early: got %0d early clocks want 0", bad); end
    n_checks++; if (x_start !== 10'h013) begin n_fail++; $display("FAIL x_start_latched: got %h want 013", x_start); end
    n_checks++; if (char_cycle !== 3'd7 || hsync_n !== 1'b0) begin n_fail++; $display("FAIL x_start_slot: got cc=%0d hs=%b want cc=7 hs=0", char_cycle, hsync_n); end
    n_checks++; if (y_start !== 10'd0) begin n_fail++; $display("FAIL y_start_hold: got %h want 000", y_start); end
  endtask

  task automatic test_rcr;
    int unsigned bf;
    goto(1016);
    reg_write(5'h05, 16'h0004);
    reg_write(5'h06, 16'h0042);
    goto(5376);
    n_checks++; if (raster_line !== 10'd16) begin n_fail++; $display("FAIL raster_pre_disp: got %0d want 16", raster_line); end
    goto(5711);
    n_checks++; if (v_disp !== 1'b0) begin n_fail++; $display("FAIL v_disp_before: got %b want 0", v_disp); end
    goto(5712);
    n_checks++; if (v_disp !== 1'b1) begin n_fail++; $display("FAIL v_disp_rise: got %b want 1", v_disp); end
    n_checks++; if (raster_line !== 10'd64) begin n_fail++; $display("FAIL raster_base: got %0d want 64", raster_line); end
    goto(6048);
    bf = 0;
    while (cyc <= 6383) begin
      if (bg_fetch === 1'b1) bf++;
      @(negedge clock);
    end
    n_checks++; if (bf != 272) begin n_fail++; $display("FAIL bg_fetch_clocks: got %0d want 272", bf); end
    n_checks++; if (raster_line !== 10'd66 || irq_flags !== 2'b00) begin n_fail++; $display("FAIL rcr_line_66: got r=%0d f=%b want r=66 f=00", raster_line, irq_flags); end
    goto(6385);
    n_checks++; if (irq_flags !== 2'b01) begin n_fail++; $display("FAIL rcr_flag_set: got %b want 01", irq_flags); end
    n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rcr_irq_n_lag: got %b want 1", irq_n); end
    goto(6386);
    n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL rcr_irq_n_low: got %b want 0", irq_n); end
    goto(6390);
    irq_ack = 2'b01;
    goto(6391);
    irq_ack = 2'b00;
    n_checks++; if (irq_flags !== 2'b00) begin n_fail++; $display("FAIL rcr_ack_clear: got %b want 00", irq_flags); end
    goto(6392);
    n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rcr_irq_n_release: got %b want 1", irq_n); end
  endtask

  task automatic test_vbl;
    reg_write(5'h05, 16'h0008);
    goto(86351);
    n_checks++; if (eol !== 1'b1 || v_disp !== 1'b1 || irq_flags !== 2'b00) begin n_fail++; $display("FAIL vbl_pre: got eol=%b vd=%b f=%b want 1 1 00", eol, v_disp, irq_flags); end
    irq_ack = 2'b10;
    goto(86352);
    irq_ack = 2'b00;
    n_checks++; if (irq_flags !== 2'b10) begin n_fail++; $display("FAIL vbl_set_vs_ack: got %b want 10", irq_flags); end
    n_checks++; if (v_disp !== 1'b0 || vsync_n !== 1'b1) begin n_fail++; $display("FAIL v_end_entry: got vd=%b vs=%b want 0 1", v_disp, vsync_n); end
    goto(86353);
    n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL vbl_irq_n_low: got %b want 0", irq_n); end
    goto(86355);
    irq_ack = 2'b10;
    goto(86356);
    irq_ack = 2'b00;
    n_checks++; if (irq_flags !== 2'b00) begin n_fail++; $display("FAIL vbl_ack_clear: got %b want 00", irq_flags); end
    goto(86357);
    n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL vbl_irq_n_release: got %b want 1", irq_n); end
  endtask

  task automatic test_frame;
    goto(87359);
    n_checks++; if (vsync_n !== 1'b1) begin n_fail++; $display("FAIL vsync_before: got %b want 1", vsync_n); end
    goto(87360);
    n_checks++; if (vsync_n !== 1'b0) begin n_fail++; $display("FAIL vsync_fall_line260: got %b want 0", vsync_n); end
    goto(88367);
    n_checks++; if (vsync_n !== 1'b0 || eol !== 1'b1) begin n_fail++; $display("FAIL vsync_last: got vs=%b eol=%b want 0 1", vsync_n, eol); end
    goto(88368);
    n_checks++; if (vsync_n !== 1'b1 || v_disp !== 1'b0) begin n_fail++; $display("FAIL frame_263_lines: got vs=%b vd=%b want 1 0", vsync_n, v_disp); end
    n_checks++; if (raster_line !== 10'd310) begin n_fail++; $display("FAIL raster_line263: got %0d want 310", raster_line); end
  endtask

  task automatic test_hdr;
    int unsigned t, hs, hd, ne;
    goto(88500);
    n_checks++; if (h_disp !== 1'b1) begin n_fail++; $display("FAIL hdr_mid_disp: got %b want 1", h_disp); end
    reg_write(5'h0B, 16'h0327);
    wait_eol(500, t);
    n_checks++; if (t != 88703) begin n_fail++; $display("FAIL hdr_current_line: got %0d want 88703", t); end
    hs = 0; hd = 0; ne = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (hsync_n === 1'b0) hs++;
      if (h_disp === 1'b1) hd++;
      if (eol === 1'b1) ne++;
    end
    n_checks++; if (eol !== 1'b1 || ne != 1) begin n_fail++; $display("FAIL hdr_line_400: got eol=%b n=%0d want 1 1", eol, ne); end
    n_checks++; if (hd != 320) begin n_fail++; $display("FAIL hdr_h_disp: got %0d want 320", hd); end
    n_checks++; if (hs != 24) begin n_fail++; $display("FAIL hdr_hsync: got %0d want 24", hs); end
  endtask

  initial begin
    test_reset(1'b0);
    test_free_run();
    test_x_start();
    test_rcr();
    test_vbl();
    test_frame();
    test_hdr();
    test_reset(1'b1);
    test_free_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
